// File: rtl/ppu_sprite_eval.sv
`timescale 1ns/10ps
`default_nettype none
// ppu_sprite_eval: per-scanline sprite evaluation that fills a 32-byte secondary OAM
// from the 64-entry primary OAM, including the diagonal-scan overflow quirk. Rev 1.0
module ppu_sprite_eval (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] scanline_i,
   input  logic [8:0] dot_i,
   input  logic       rendering_en_i,
   input  logic       sprite_16_i,
   output logic [7:0] oam_addr_o,
   output logic       oam_req_o,
   input  logic [7:0] oam_data_i,
   input  logic [4:0] sec_addr_i,
   output logic [7:0] sec_data_o,
   output logic [3:0] sprite_count_o,
   output logic       sprite0_o,
   output logic       overflow_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CLEAR     = 3'd1,
      S_EVAL_Y    = 3'd2,
      S_EVAL_COPY = 3'd3,
      S_EVAL_OVF  = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t     r_state, w_state_nx;
   logic [5:0] r_n, w_n_nx;
   logic [1:0] r_m, w_m_nx;
   logic [3:0] r_cnt, w_cnt_nx;
   logic       r_sp0, w_sp0_nx;
   logic [7:0] r_byte;
   logic [7:0] r_sec [32];

   logic       w_we;
   logic [4:0] w_wa;
   logic [7:0] w_wd;
   logic       w_ovf_set;
   logic       w_active;
   logic       w_even;
   logic [8:0] w_diff;
   logic       w_in_range;
   logic [4:0] w_clr_idx;
   logic       w_eval_nx;
   logic       w_work_nx;

   assign w_active   = rendering_en_i && (scanline_i <= 9'd239);
   assign w_even     = ~dot_i[0];
   assign w_diff     = {1'b0, scanline_i[7:0]} - {1'b0, r_byte};
   assign w_in_range = ~w_diff[8] && (w_diff < (sprite_16_i ? 9'd16 : 9'd8));
   // Dot 2k clears byte k-1; dot 64 wraps dot_i[5:1] to 0, giving index 31.
   assign w_clr_idx  = dot_i[5:1] - 5'd1;
   assign sec_data_o = r_sec[sec_addr_i];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_n_nx     = r_n;
      w_m_nx     = r_m;
      w_cnt_nx   = r_cnt;
      w_sp0_nx   = r_sp0;
      w_we       = 1'b0;
      w_wa       = 5'd0;
      w_wd       = 8'hFF;
      w_ovf_set  = 1'b0;
      if (w_even) begin
         case (r_state)
            S_CLEAR: begin
               w_we = 1'b1;
               w_wa = w_clr_idx;
               if (dot_i == 9'd64) begin
                  w_cnt_nx   = 4'd0;
                  w_n_nx     = 6'd0;
                  w_m_nx     = 2'd0;
                  w_sp0_nx   = 1'b0;
                  w_state_nx = S_EVAL_Y;
               end
            end
            S_EVAL_Y: begin
               w_we = 1'b1;
               w_wa = {r_cnt[2:0], 2'b00};
               w_wd = r_byte;
               if (w_in_range) begin
                  w_m_nx     = 2'd1;
                  w_state_nx = S_EVAL_COPY;
                  if (r_n == 6'd0) w_sp0_nx = 1'b1;
               end else begin
                  w_n_nx = r_n + 6'd1;
                  if (r_n == 6'd63) w_state_nx = S_DONE;
               end
            end
            S_EVAL_COPY: begin
               w_we = 1'b1;
               w_wa = {r_cnt[2:0], r_m};
               w_wd = r_byte;
               if (r_m == 2'd3) begin
                  w_cnt_nx = r_cnt + 4'd1;
                  w_n_nx   = r_n + 6'd1;
                  w_m_nx   = 2'd0;
                  if (r_n == 6'd63)      w_state_nx = S_DONE;
                  else if (r_cnt == 4'd7) w_state_nx = S_EVAL_OVF;
                  else                   w_state_nx = S_EVAL_Y;
               end else begin
                  w_m_nx = r_m + 2'd1;
               end
            end
            S_EVAL_OVF: begin
               if (w_in_range) begin
                  w_ovf_set  = 1'b1;
                  w_state_nx = S_DONE;
               end else begin
                  // Both n and m advance: the hardware's diagonal walk through OAM.
                  w_n_nx = r_n + 6'd1;
                  w_m_nx = r_m + 2'd1;
                  if (r_n == 6'd63) w_state_nx = S_DONE;
               end
            end
            default: ;
         endcase
      end
      if (dot_i == 9'd256 && r_state != S_IDLE) w_state_nx = S_DONE;
      if (dot_i == 9'd0)                         w_state_nx = S_CLEAR;
      if (!w_active)                             w_state_nx = S_IDLE;
   end

   assign w_eval_nx = (w_state_nx == S_EVAL_Y) || (w_state_nx == S_EVAL_COPY) ||
                      (w_state_nx == S_EVAL_OVF);
   assign w_work_nx = w_eval_nx || (w_state_nx == S_CLEAR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n            <= 6'd0;
         r_m            <= 2'd0;
         r_cnt          <= 4'd0;
         r_sp0          <= 1'b0;
         r_byte         <= 8'd0;
         oam_addr_o     <= 8'd0;
         oam_req_o      <= 1'b0;
         sprite_count_o <= 4'd0;
         sprite0_o      <= 1'b0;
         overflow_o     <= 1'b0;
         for (int i = 0; i < 32; i++) r_sec[i] <= 8'hFF;
      end else begin
         r_n        <= w_n_nx;
         r_m        <= w_m_nx;
         r_cnt      <= w_cnt_nx;
         r_sp0      <= w_sp0_nx;
         oam_req_o  <= w_work_nx;
         oam_addr_o <= w_eval_nx ? {w_n_nx, w_m_nx} : 8'd0;
         if (dot_i[0]) r_byte <= oam_data_i;
         if (w_we)     r_sec[w_wa] <= w_wd;
         if (dot_i == 9'd256 && r_state != S_IDLE && w_active) begin
            sprite_count_o <= w_cnt_nx;
            sprite0_o      <= w_sp0_nx;
         end
         if (scanline_i == 9'd261 && dot_i == 9'd1) overflow_o <= 1'b0;
         else if (w_ovf_set)                         overflow_o <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ppu_sprite_eval.sv
`timescale 1ns/10ps
`default_nettype none
// tb_ppu_sprite_eval: directed scanline scenarios for ppu_sprite_eval. Rev 1.0
module tb_ppu_sprite_eval;

   logic       clk;
   logic       rst;
   logic [8:0] scanline_i;
   logic [8:0] dot_i;
   logic       rendering_en_i;
   logic       sprite_16_i;
   logic [7:0] oam_addr_o;
   logic       oam_req_o;
   logic [7:0] oam_data_i;
   logic [4:0] sec_addr_i;
   logic [7:0] sec_data_o;
   logic [3:0] sprite_count_o;
   logic       sprite0_o;
   logic       overflow_o;

   logic [7:0] oam [256];
   int checks;
   int failures;

   assign oam_data_i = oam[oam_addr_o];

   ppu_sprite_eval dut (
      .clk            (clk),
      .rst            (rst),
      .scanline_i     (scanline_i),
      .dot_i          (dot_i),
      .rendering_en_i (rendering_en_i),
      .sprite_16_i    (sprite_16_i),
      .oam_addr_o     (oam_addr_o),
      .oam_req_o      (oam_req_o),
      .oam_data_i     (oam_data_i),
      .sec_addr_i     (sec_addr_i),
      .sec_data_o     (sec_data_o),
      .sprite_count_o (sprite_count_o),
      .sprite0_o      (sprite0_o),
      .overflow_o     (overflow_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (dot_i == 9'd340) begin
         dot_i      = 9'd0;
         scanline_i = (scanline_i == 9'd261) ? 9'd0 : scanline_i + 9'd1;
      end else begin
         dot_i = dot_i + 9'd1;
      end
   endtask

   task automatic run_to(input int d);
      for (int i = 0; i < 400 && dot_i != d[8:0]; i++) tick();
   endtask

   task automatic start_line(input int l);
      @(posedge clk);
      #1;
      scanline_i = l[8:0];
      dot_i      = 9'd0;
   endtask

   task automatic read_sec(input int a, output logic [7:0] v);
      sec_addr_i = a[4:0];
      #0.1;
      v = sec_data_o;
   endtask

   task automatic oam_fill_ff();
      for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      rendering_en_i = 1'b0;
      repeat (3) tick();
      checks++; if (oam_addr_o !== 8'd0) begin failures++; $display("FAIL rst_addr got=%h exp=00", oam_addr_o); end
      checks++; if (oam_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", oam_req_o); end
      checks++; if (sprite_count_o !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", sprite_count_o); end
      checks++; if (sprite0_o !== 1'b0) begin failures++; $display("FAIL rst_sp0 got=%b exp=0", sprite0_o); end
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow_o); end
      for (int i = 0; i < 32; i++) begin
         read_sec(i, v);
         checks++; if (v !== 8'hFF) begin failures++; $display("FAIL rst_sec[%0d] got=%h exp=ff", i, v); end
      end
      rst = 1'b0;
      rendering_en_i = 1'b1;
   endtask

   task automatic test_single_sprite();
      logic [7:0] v;
      logic [7:0] exp_b [4];
      exp_b = '{8'h05, 8'h21, 8'h03, 8'h40};
      oam_fill_ff();
      for (int i = 0; i < 4; i++) oam[i] = exp_b[i];
      sprite_16_i = 1'b0;
      start_line(12);
      checks++; if (oam_req_o !== 1'b0) begin failures++; $display("FAIL single_req_dot0 got=%b exp=0", oam_req_o); end
      tick();
      checks++; if (oam_req_o !== 1'b1) begin failures++; $display("FAIL single_req_dot1 got=%b exp=1", oam_req_o); end
      run_to(65);
      checks++; if (oam_addr_o !== 8'd0) begin failures++; $display("FAIL single_addr65 got=%h exp=00", oam_addr_o); end
      run_to(67);
      checks++; if (oam_addr_o !== 8'd1) begin failures++; $display("FAIL single_addr67 got=%h exp=01", oam_addr_o); end
      run_to(257);
      checks++; if (sprite_count_o !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", sprite_count_o); end
      checks++; if (sprite0_o !== 1'b1) begin failures++; $display("FAIL single_sp0 got=%b exp=1", sprite0_o); end
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL single_ovf got=%b exp=0", overflow_o); end
      checks++; if (oam_req_o !== 1'b0) begin failures++; $display("FAIL single_req257 got=%b exp=0", oam_req_o); end
      for (int i = 0; i < 4; i++) begin
         read_sec(i, v);
         checks++; if (v !== exp_b[i]) begin failures++; $display("FAIL single_sec[%0d] got=%h exp=%h", i, v, exp_b[i]); end
      end
      read_sec(4, v);
      checks++; if (v !== 8'hFF) begin failures++; $display("FAIL single_sec[4] got=%h exp=ff", v); end
   endtask

   task automatic test_clear_empty();
      logic [7:0] v;
      oam_fill_ff();
      start_line(10);
      run_to(65);
      for (int i = 0; i < 32; i++) begin
         read_sec(i, v);
         checks++; if (v !== 8'hFF) begin failures++; $display("FAIL clear_sec[%0d] got=%h exp=ff", i, v); end
      end
      run_to(257);
      checks++; if (sprite_count_o !== 4'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", sprite_count_o); end
      checks++; if (sprite0_o !== 1'b0) begin failures++; $display("FAIL empty_sp0 got=%b exp=0", sprite0_o); end
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL empty_ovf got=%b exp=0", overflow_o); end
   endtask

   task automatic test_y_zero();
      logic [7:0] v;
      oam_fill_ff();
      oam[8] = 8'h00; oam[9] = 8'hAA; oam[10] = 8'hBB; oam[11] = 8'hCC;
      sprite_16_i = 1'b0;
      start_line(12);
      run_to(257);
      checks++; if (sprite_count_o !== 4'd0) begin failures++; $display("FAIL y0_8x8_count got=%0d exp=0", sprite_count_o); end
      sprite_16_i = 1'b1;
      start_line(12);
      run_to(257);
      checks++; if (sprite_count_o !== 4'd1) begin failures++; $display("FAIL y0_8x16_count got=%0d exp=1", sprite_count_o); end
      checks++; if (sprite0_o !== 1'b0) begin failures++; $display("FAIL y0_8x16_sp0 got=%b exp=0", sprite0_o); end
      read_sec(0, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL y0_sec[0] got=%h exp=00", v); end
      read_sec(1, v);
      checks++; if (v !== 8'hAA) begin failures++; $display("FAIL y0_sec[1] got=%h exp=aa", v); end
      read_sec(3, v);
      checks++; if (v !== 8'hCC) begin failures++; $display("FAIL y0_sec[3] got=%h exp=cc", v); end
      sprite_16_i = 1'b0;
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      oam_fill_ff();
      for (int e = 0; e < 9; e++) begin
         oam[4*e]   = 8'd20;
         oam[4*e+1] = 8'(e);
         oam[4*e+2] = 8'h00;
         oam[4*e+3] = 8'h00;
      end
      start_line(22);
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b exp=0", overflow_o); end
      run_to(257);
      checks++; if (sprite_count_o !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", sprite_count_o); end
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
      checks++; if (sprite0_o !== 1'b1) begin failures++; $display("FAIL ovf_sp0 got=%b exp=1", sprite0_o); end
      read_sec(28, v);
      checks++; if (v !== 8'd20) begin failures++; $display("FAIL ovf_sec[28] got=%h exp=14", v); end
      read_sec(29, v);
      checks++; if (v !== 8'd7) begin failures++; $display("FAIL ovf_sec[29] got=%h exp=07", v); end
      start_line(23);
      run_to(257);
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky23 got=%b exp=1", overflow_o); end
      start_line(261);
      tick();
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_261d1 got=%b exp=1", overflow_o); end
      tick();
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_261d2 got=%b exp=0", overflow_o); end
      checks++; if (oam_req_o !== 1'b0) begin failures++; $display("FAIL ovf_261_req got=%b exp=0", oam_req_o); end
   endtask

   task automatic test_diagonal();
      oam_fill_ff();
      for (int e = 0; e < 8; e++) begin
         oam[4*e]   = 8'd20;
         oam[4*e+1] = 8'(e);
      end
      start_line(22);
      run_to(257);
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL diag_ctrl_ovf got=%b exp=0", overflow_o); end
      checks++; if (sprite_count_o !== 4'd8) begin failures++; $display("FAIL diag_ctrl_count got=%0d exp=8", sprite_count_o); end
      oam[37] = 8'd22;
      start_line(22);
      run_to(257);
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL diag_ovf got=%b exp=1", overflow_o); end
   endtask

   task automatic test_reset_and_drop();
      logic [7:0] v;
      oam_fill_ff();
      oam[0] = 8'h05; oam[1] = 8'h21; oam[2] = 8'h03; oam[3] = 8'h40;
      start_line(12);
      run_to(257);
      checks++; if (sprite_count_o !== 4'd1) begin failures++; $display("FAIL rd_pre_count got=%0d exp=1", sprite_count_o); end
      start_line(13);
      run_to(100);
      rst = 1'b1;
      #1;
      checks++; if (sprite_count_o !== 4'd0) begin failures++; $display("FAIL rd_rst_count got=%0d exp=0", sprite_count_o); end
      checks++; if (sprite0_o !== 1'b0) begin failures++; $display("FAIL rd_rst_sp0 got=%b exp=0", sprite0_o); end
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL rd_rst_ovf got=%b exp=0", overflow_o); end
      checks++; if (oam_req_o !== 1'b0) begin failures++; $display("FAIL rd_rst_req got=%b exp=0", oam_req_o); end
      checks++; if (oam_addr_o !== 8'd0) begin failures++; $display("FAIL rd_rst_addr got=%h exp=00", oam_addr_o); end
      for (int i = 0; i < 32; i++) begin
         read_sec(i, v);
         checks++; if (v !== 8'hFF) begin failures++; $display("FAIL rd_rst_sec[%0d] got=%h exp=ff", i, v); end
      end
      tick();
      rst = 1'b0;
      start_line(12);
      run_to(257);
      checks++; if (sprite_count_o !== 4'd1) begin failures++; $display("FAIL rd_re_count got=%0d exp=1", sprite_count_o); end
      start_line(13);
      run_to(120);
      checks++; if (oam_req_o !== 1'b1) begin failures++; $display("FAIL rd_req120 got=%b exp=1", oam_req_o); end
      rendering_en_i = 1'b0;
      tick();
      checks++; if (oam_req_o !== 1'b0) begin failures++; $display("FAIL rd_drop_req got=%b exp=0", oam_req_o); end
      run_to(257);
      checks++; if (sprite_count_o !== 4'd1) begin failures++; $display("FAIL rd_drop_count got=%0d exp=1", sprite_count_o); end
      checks++; if (sprite0_o !== 1'b1) begin failures++; $display("FAIL rd_drop_sp0 got=%b exp=1", sprite0_o); end
      checks++; if (oam_req_o !== 1'b0) begin failures++; $display("FAIL rd_drop_req257 got=%b exp=0", oam_req_o); end
      rendering_en_i = 1'b1;
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst            = 1'b1;
      scanline_i     = 9'd0;
      dot_i          = 9'd0;
      rendering_en_i = 1'b0;
      sprite_16_i    = 1'b0;
      sec_addr_i     = 5'd0;
      for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
      test_reset();
      test_single_sprite();
      test_clear_empty();
      test_y_zero();
      test_overflow();
      test_diagonal();
      test_reset_and_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
